// File: rtl/axi4_store_buffer_if.sv
// Store buffer bus bundle: LSU store handshake plus
// the write-module start/done pair and status.
interface axi4_store_buffer_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
);
  logic             ST_VALID;
  logic             ST_READY;
  logic [63:0]      ST_ADDR;
  logic [63:0]      ST_DATA;
  logic [63:0]      WRITE_ADDR;
  logic [63:0]      WRITE_DATA;
  logic             WRITE_START;
  logic             WRITE_DONE;
  logic             BUF_EMPTY;
  logic [CNT_W-1:0] BUF_COUNT;

  modport slave (
    input  ST_VALID, ST_ADDR, ST_DATA,
    input  WRITE_DONE,
    output ST_READY, WRITE_ADDR, WRITE_DATA,
    output WRITE_START, BUF_EMPTY, BUF_COUNT
  );

  modport master (
    output ST_VALID, ST_ADDR, ST_DATA,
    output WRITE_DONE,
    input  ST_READY, WRITE_ADDR, WRITE_DATA,
    input  WRITE_START, BUF_EMPTY, BUF_COUNT
  );
endinterface

// File: rtl/axi4_store_buffer.sv
// In-order store FIFO feeding the AXI4-lite write
// module one request at a time via START/DONE.
module axi4_store_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input logic                  CLK,
  input logic                  RST_N,
  axi4_store_buffer_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic             start_q;
  logic [63:0]      addr_q [DEPTH];
  logic [63:0]      data_q [DEPTH];

  logic full;
  logic push;
  logic pop;

  assign full = (count_q == CNT_W'(DEPTH));
  assign push = bus.ST_VALID && !full;
  assign pop  = (state_q == ISSUE) && bus.WRITE_DONE;

  assign bus.ST_READY    = !full;
  assign bus.WRITE_START = start_q;
  assign bus.WRITE_ADDR  = addr_q[rd_ptr_q];
  assign bus.WRITE_DATA  = data_q[rd_ptr_q];
  assign bus.BUF_COUNT   = count_q;
  assign bus.BUF_EMPTY   = (count_q == '0) &&
                           (state_q != ISSUE);

  // Pointer and occupancy next-state.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Issue FSM; GAP forces one low START cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) state_d = ISSUE;
      end
      ISSUE: begin
        if (bus.WRITE_DONE) state_d = GAP;
      end
      GAP: begin
        state_d = (count_q != '0) ? ISSUE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state; START registered from next state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      start_q  <= (state_d == ISSUE);
    end
  end

  // Entry storage, written on accepted pushes.
  always_ff @(posedge CLK) begin
    if (push) begin
      addr_q[wr_ptr_q] <= bus.ST_ADDR;
      data_q[wr_ptr_q] <= bus.ST_DATA;
    end
  end
endmodule

// File: doc/axi4_store_buffer.md
# axi4_store_buffer

Store-request FIFO sitting directly upstream of the AXI4-lite write module. It accepts 64-bit store requests from the LSU with a valid/ready handshake and buffers up to DEPTH of them. It issues them one at a time, in order, on the write module's WRITE_START / WRITE_DONE interface. The pipeline therefore never stalls on a single outstanding bus write.

## Interface
- DEPTH, 4: number of buffered stores; power of two, ≥2
- CNT_W, $clog2(DEPTH+1): width of BUF_COUNT
- CLK  input  1  single clock; all state updates on rising edge
- RST_N  input  1  asynchronous, active-low reset
- ST_VALID  input  1  LSU presents a store request
- ST_READY  output  1  buffer can accept a store this cycle
- ST_ADDR  input  64  store address
- ST_DATA  input  64  store data
- WRITE_ADDR  output  64  address of head entry, to write module
- WRITE_DATA  output  64  data of head entry, to write module
- WRITE_START  output  1  request to write module; registered level
- WRITE_DONE  input  1  write module completion, single-cycle pulse
- BUF_EMPTY  output  1  no entries held and no write in flight
- BUF_COUNT  output  CNT_W  number of occupied entries, including the in-flight head

## Operation
- Storage: DEPTH-entry circular array of {addr, data}.
  - Read pointer rd_ptr and write pointer wr_ptr are log2(DEPTH) bits wide and wrap modulo DEPTH.
  - Occupancy is held in count (0..DEPTH).
- Push: occurs on ST_VALID && ST_READY.
  - {ST_ADDR, ST_DATA} is written at wr_ptr; wr_ptr is incremented.
- ST_READY = (count != DEPTH). It is derived from the registered count only.
  - When full, a push is refused even if a pop occurs in the same cycle.
- Pop: occurs on an edge where state==ISSUE && WRITE_DONE. rd_ptr is incremented.
- count update: +1 on push only, -1 on pop only, unchanged on push and pop together.
- WRITE_ADDR / WRITE_DATA are driven from entry[rd_ptr].
  - They are stable for the whole time WRITE_START is high, because the head is not overwritten while count>0.
- FSM states: IDLE, ISSUE, GAP.
  - IDLE: if count!=0, go to ISSUE; otherwise stay.
  - ISSUE: WRITE_START=1. If WRITE_DONE, pop and go to GAP; otherwise stay.
  - GAP: WRITE_START=0 for exactly one cycle, so the write module sees the request drop. Then go to ISSUE if count!=0 (post-pop value), otherwise go to IDLE.
- WRITE_START is a register equal to (next state == ISSUE); it is glitch-free.
- WRITE_DONE is ignored in IDLE and GAP.
- BUF_EMPTY = (count==0) && (state!=ISSUE).
- Ordering: strict FIFO. No merging or forwarding.

## Timing
- Reset values:
  - WRITE_START=0, ST_READY=1, BUF_EMPTY=1, BUF_COUNT=0.
  - State=IDLE, pointers=0.
  - WRITE_ADDR/WRITE_DATA = entry[0]; this value is don't-care.
- Asserting RST_N mid-write:
  - Buffered entries are discarded.
  - WRITE_START drops asynchronously.
  - A WRITE_DONE arriving after reset release is ignored, because the FSM is in IDLE.
- Push at edge E into an empty, IDLE buffer:
  - count=1 after E.
  - FSM enters ISSUE at edge E+1, so WRITE_START is high from E+1.
- WRITE_DONE sampled high at edge D:
  - WRITE_START is low after D.
  - If further entries remain, WRITE_START is high again after D+1.
  - Minimum spacing between consecutive starts is 1 low cycle.
- Full → not-full: ST_READY rises the cycle after the popping edge.
- Throughput: one store per (write-module latency + 1) cycles.

## Test plan
- Single store: push A=0x8000_0010, D=0x1122_3344_5566_7788 at edge E.
  - Required: WRITE_START=1 from E+1 with those values on WRITE_ADDR/WRITE_DATA.
  - WRITE_DONE pulse at E+3 gives WRITE_START=0 and BUF_EMPTY=1 after E+4.
- Fill: push 4 stores back-to-back while WRITE_DONE is held low.
  - Required: BUF_COUNT=4 and ST_READY=0, and a 5th ST_VALID is not accepted.
  - After one WRITE_DONE, ST_READY=1 the next cycle and BUF_COUNT=3.
- Order and wrap: push 10 stores with addresses 0x0..0x48 in steps of 8, responding with WRITE_DONE 2 cycles after each start.
  - Required: addresses are issued in order, pointers wrap twice, and each start is preceded by exactly one low cycle after the previous WRITE_DONE.
- Simultaneous push and pop: count=2 and state ISSUE; on one edge, ST_VALID and WRITE_DONE are both high.
  - Required: BUF_COUNT stays 2, the next head is issued after GAP, and the new entry is the last issued.
- Spurious WRITE_DONE: pulse WRITE_DONE while IDLE with the buffer empty.
  - Required: no pointer or count change, and WRITE_START stays 0.
- Reset mid-operation: with 3 entries held and WRITE_START=1, pull RST_N low for 1 cycle.
  - Required: WRITE_START=0 immediately, BUF_COUNT=0, ST_READY=1.
  - A subsequent WRITE_DONE has no effect.
